// File: rtl/cla_add_pipe.sv
// Pipelined carry-lookahead adder/subtractor (ADD/SUB/ADDC/SUBB) with valid/ready handshake.
// Optional feature macro: ADD_SAT_EN (ADD/SUB saturate on signed overflow).
module cla_add_pipe #(
   parameter int WIDTH  = 32,
   parameter int GROUP  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = WIDTH / GROUP;
`ifdef ADD_SAT_EN
   localparam int SATW = 1;
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
`else
   localparam int SATW = 0;
`endif
   // Stage word layouts, LSB first: p, g, {gp, gg, c0 | gc[NG:0]}, optional saturate flag.
   localparam int S1W   = 2*WIDTH + 2*NG + 1 + SATW;
   localparam int S2W   = 2*WIDTH + NG + 1 + SATW;
   localparam int GP_LO = 2*WIDTH;
   localparam int GG_LO = 2*WIDTH + NG;
   localparam int C0_B  = 2*WIDTH + 2*NG;

   function automatic logic grp_gen(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g);
      logic r;
      logic t;
      r = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
         t = g[j];
         for (int m = j + 1; m < GROUP; m++) t = t & p[m];
         r = r | t;
      end
      return r;
   endfunction

   // Carry into every bit of one group, each one a flat sum of products of the group-local p/g.
   function automatic logic [GROUP-1:0] bit_carries(input logic [GROUP-1:0] p,
                                                    input logic [GROUP-1:0] g,
                                                    input logic             ci);
      logic [GROUP-1:0] c;
      logic t;
      c = '0;
      for (int i = 0; i < GROUP; i++) begin
         t = ci;
         for (int j = 0; j < i; j++) t = t & p[j];
         c[i] = t;
         for (int j = 0; j < i; j++) begin
            t = g[j];
            for (int m = j + 1; m < i; m++) t = t & p[m];
            c[i] = c[i] | t;
         end
      end
      return c;
   endfunction

   function automatic logic [NG:0] grp_carry(input logic [NG-1:0] gp,
                                             input logic [NG-1:0] gg,
                                             input logic          c0);
      logic [NG:0] c;
      logic t;
      c = '0;
      for (int k = 0; k <= NG; k++) begin
         t = c0;
         for (int j = 0; j < k; j++) t = t & gp[j];
         c[k] = t;
         for (int j = 0; j < k; j++) begin
            t = gg[j];
            for (int m = j + 1; m < k; m++) t = t & gp[m];
            c[k] = c[k] | t;
         end
      end
      return c;
   endfunction

   logic             stall;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic [WIDTH-1:0] p0;
   logic [WIDTH-1:0] g0;
   logic [NG-1:0]    gp0;
   logic [NG-1:0]    gg0;
   logic [S1W-1:0]   st0;
   logic [S1W-1:0]   st1;
   logic             v1;
   logic [NG:0]      gc1;
   logic [S2W-1:0]   st1c;
   logic [S2W-1:0]   st2;
   logic             v2;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] res_raw;
   logic [WIDTH-1:0] res_sum;
   logic             res_cout;
   logic             res_ovf;

   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;
   logic             zero_d, zero_q;

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = ~stall;

   // Operand prep and per-bit / per-group propagate-generate.
   always_comb begin
      b_eff = b;
      c0    = 1'b0;
      case (op)
         2'b00:   begin b_eff = b;  c0 = 1'b0; end
         2'b01:   begin b_eff = ~b; c0 = 1'b1; end
         2'b10:   begin b_eff = b;  c0 = cin;  end
         2'b11:   begin b_eff = ~b; c0 = ~cin; end
         default: begin b_eff = b;  c0 = 1'b0; end
      endcase
      p0  = a ^ b_eff;
      g0  = a & b_eff;
      gp0 = '0;
      gg0 = '0;
      for (int k = 0; k < NG; k++) begin
         gp0[k] = &p0[k*GROUP +: GROUP];
         gg0[k] = grp_gen(p0[k*GROUP +: GROUP], g0[k*GROUP +: GROUP]);
      end
   end

`ifdef ADD_SAT_EN
   assign st0 = {~op[1], c0, gg0, gp0, g0, p0};
`else
   assign st0 = {c0, gg0, gp0, g0, p0};
`endif

   if (STAGES >= 2) begin : g_reg_pg
      logic [S1W-1:0] st1_d, st1_q;
      logic           v1_d, v1_q;

      // Next state of the P/G stage: advance when not stalled, capture data only for real beats.
      always_comb begin
         st1_d = st1_q;
         v1_d  = v1_q;
         if (!stall) begin
            v1_d = in_valid;
            if (in_valid) begin
               st1_d = st0;
            end else begin
               st1_d = st1_q;
            end
         end else begin
            v1_d = v1_q;
         end
      end

      // P/G stage register.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            st1_q <= '0;
            v1_q  <= 1'b0;
         end else begin
            st1_q <= st1_d;
            v1_q  <= v1_d;
         end
      end

      assign st1 = st1_q;
      assign v1  = v1_q;
   end else begin : g_pass_pg
      assign st1 = st0;
      assign v1  = in_valid;
   end

   assign gc1 = grp_carry(st1[GP_LO +: NG], st1[GG_LO +: NG], st1[C0_B]);
`ifdef ADD_SAT_EN
   assign st1c = {st1[S1W-1], gc1, st1[2*WIDTH-1:0]};
`else
   assign st1c = {gc1, st1[2*WIDTH-1:0]};
`endif

   if (STAGES >= 3) begin : g_reg_gc
      logic [S2W-1:0] st2_d, st2_q;
      logic           v2_d, v2_q;

      // Next state of the group-carry stage.
      always_comb begin
         st2_d = st2_q;
         v2_d  = v2_q;
         if (!stall) begin
            v2_d = v1;
            if (v1) begin
               st2_d = st1c;
            end else begin
               st2_d = st2_q;
            end
         end else begin
            v2_d = v2_q;
         end
      end

      // Group-carry stage register.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            st2_q <= '0;
            v2_q  <= 1'b0;
         end else begin
            st2_q <= st2_d;
            v2_q  <= v2_d;
         end
      end

      assign st2 = st2_q;
      assign v2  = v2_q;
   end else begin : g_pass_gc
      assign st2 = st1c;
      assign v2  = v1;
   end

   // In-group bit carries, sum and overflow from the group carry-ins.
   always_comb begin
      carry = '0;
      for (int k = 0; k < NG; k++) begin
         carry[k*GROUP +: GROUP] = bit_carries(st2[k*GROUP +: GROUP],
                                               st2[WIDTH + k*GROUP +: GROUP],
                                               st2[2*WIDTH + k]);
      end
      res_raw  = st2[WIDTH-1:0] ^ carry;
      res_cout = st2[2*WIDTH + NG];
      res_ovf  = carry[WIDTH-1] ^ res_cout;
   end

`ifdef ADD_SAT_EN
   // On overflow a and b' share their MSB, so g[MSB] equals the sign of a.
   assign res_sum = (st2[S2W-1] & res_ovf) ? (st2[2*WIDTH-1] ? SMIN : SMAX) : res_raw;
`else
   assign res_sum = res_raw;
`endif

   // Next state of the output register.
   always_comb begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      if (!stall) begin
         out_valid_d = v2;
         if (v2) begin
            sum_d  = res_sum;
            cout_d = res_cout;
            ovf_d  = res_ovf;
            zero_d = ~|res_sum;
         end else begin
            sum_d  = sum_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_cla_add_pipe.sv
// Scoreboard bench for cla_add_pipe: directed corner beats, stall, mid-flight reset, random ops.
module tb_cla_add_pipe;
   parameter int W = 32;
   parameter int G = 8;
   parameter int S = 2;

   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [1:0]   op = 2'b00;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   int   checks = 0;
   int   passes = 0;
   int   beat_n = 0;
   int   rdy_mode = 0;
   exp_t sb[$];

   cla_add_pipe #(.WIDTH(W), .GROUP(G), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   // Reference: signed/unsigned integer arithmetic on the operands as numbers.
   function automatic exp_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                  input logic [1:0] op_i, input logic cin_i);
      exp_t   r;
      longint lim  = 64'sd1 <<< W;
      longint smax = (lim >>> 1) - 64'sd1;
      longint smin = -(lim >>> 1);
      longint ua   = longint'(a_i);
      longint ub   = longint'(b_i);
      longint sa   = longint'($signed(a_i));
      longint sb_v = longint'($signed(b_i));
      longint ci   = op_i[1] ? longint'(cin_i) : 64'sd0;
      longint ures;
      longint sres;
      if (!op_i[0]) begin
         ures   = ua + ub + ci;
         sres   = sa + sb_v + ci;
         r.cout = (ures >= lim);
      end else begin
         ures   = ua - ub - ci;
         sres   = sa - sb_v - ci;
         r.cout = (ures >= 64'sd0);
      end
      r.sum = W'(ures);
      r.ovf = (sres > smax) || (sres < smin);
`ifdef ADD_SAT_EN
      if (r.ovf && !op_i[1]) r.sum = (sa < 64'sd0) ? MIN : MAX;
`endif
      r.zero = (r.sum == '0);
      return r;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic v, input logic z);
      exp_t r;
      r.sum = s; r.cout = c; r.ovf = v; r.zero = z;
      return r;
   endfunction

   task automatic chk(input string name, input longint got, input longint expv);
      checks++;
      if (got == expv) passes++;
      else $display("FAIL %s got=%0h exp=%0h", name, got, expv);
   endtask

   // Present one beat and hold it until accepted; the expectation is queued on acceptance.
   task automatic drive(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [1:0] op_i, input logic cin_i, input exp_t e);
      logic acc;
      acc = 1'b0;
      #1;
      a = a_i; b = b_i; op = op_i; cin = cin_i; in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         if (acc) break;
      end
      if (acc) sb.push_back(e);
      else chk("accept_timeout", 0, 1);
   endtask

   task automatic idle();
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 500 && sb.size() != 0; n++) @(posedge clk);
      chk("drain_left", sb.size(), 0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_sum"}, sum, 0);
      chk({tag, "_cout"}, cout, 0);
      chk({tag, "_ovf"}, ovf, 0);
      chk({tag, "_zero"}, zero, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return MIN;
         3:       return MAX;
         4:       return W'(1);
         default: return W'($urandom);
      endcase
   endfunction

   // Consumer-side ready generator for the random phase.
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: handshake rule on in_ready and in-order comparison of every output transfer.
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      if (rst_n) begin
         checks++;
         if (in_ready === !(out_valid && !out_ready)) passes++;
         else $display("FAIL in_ready got=%0b exp=%0b", in_ready, !(out_valid && !out_ready));
         if (out_valid && out_ready) begin
            checks++;
            got = {sum, cout, ovf, zero};
            if (sb.size() == 0) begin
               $display("FAIL spurious_out got sum=%0h exp=no beat", sum);
            end else begin
               e = sb.pop_front();
               if (got === e) passes++;
               else $display("FAIL beat%0d got sum=%0h c=%0b v=%0b z=%0b exp sum=%0h c=%0b v=%0b z=%0b",
                             beat_n, got.sum, got.cout, got.ovf, got.zero, e.sum, e.cout, e.ovf, e.zero);
            end
            beat_n++;
         end
      end
   end

   initial begin
      int lat;
      bit seen;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_reset_state("rst");

      // All-ones + 1 with latency measured from the edge preceding the beat.
      @(posedge clk);
      #1;
      a = '1; b = W'(1); op = 2'b00; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      seen = 1'b0;
      sb.push_back(mk('0, 1'b1, 1'b0, 1'b1));
      #1 in_valid = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      chk("latency", lat, S);
      drain();

      // Signed overflow on SUB, carry across group 0->1, borrow chain.
`ifdef ADD_SAT_EN
      drive(MIN, W'(1), 2'b01, 1'b0, mk(MIN, 1'b1, 1'b1, 1'b0));
`else
      drive(MIN, W'(1), 2'b01, 1'b0, mk(MAX, 1'b1, 1'b1, 1'b0));
`endif
      drive(W'(255), '0, 2'b10, 1'b1, mk(W'(256), 1'b0, 1'b0, 1'b0));
      drive(W'(5), W'(3), 2'b11, 1'b1, mk(W'(1), 1'b1, 1'b0, 1'b0));
      drive(W'(7), W'(7), 2'b01, 1'b1, mk('0, 1'b1, 1'b0, 1'b1));
      idle();
      drain();

      // Eight back-to-back beats with the consumer stalling for three cycles.
      rdy_mode = 2;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [W-1:0] ra, rb;
               logic [1:0]   rop;
               logic         rc;
               ra = pick(); rb = pick(); rop = 2'($urandom_range(0, 3)); rc = 1'($urandom_range(0, 1));
               drive(ra, rb, rop, rc, model(ra, rb, rop, rc));
            end
            idle();
         end
         begin
            repeat (3) @(posedge clk);
            #2 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #2 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two beats in flight: both must vanish.
      rdy_mode = 0;
      out_ready = 1'b1;
      drive(W'(100), W'(23), 2'b00, 1'b0, model(W'(100), W'(23), 2'b00, 1'b0));
      drive(W'(9), W'(4), 2'b01, 1'b0, model(W'(9), W'(4), 2'b01, 1'b0));
      #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_reset_state("midrst");
      repeat (8) @(posedge clk);

      // Random ops against the reference model with a randomly stalling consumer.
      rdy_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] ra, rb;
         logic [1:0]   rop;
         logic         rc;
         ra = pick(); rb = pick(); rop = 2'($urandom_range(0, 3)); rc = 1'($urandom_range(0, 1));
         drive(ra, rb, rop, rc, model(ra, rb, rop, rc));
      end
      idle();
      drain();
      rdy_mode = 0;
      #1 out_ready = 1'b1;
      repeat (4) @(posedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
